// File: rtl/dff_response_checker.sv
// ---------------------------------------------------------------------------
// dff_response_checker
//   Monitor that sits beside a D flip-flop with active-low asynchronous clear
//   and preset. It keeps its own reference copy of the flop, predicts Q for
//   every rising edge, and flags Q mismatches and Q/Qbar complement violations.
//
// Ports
//   clock        in   rising-edge clock shared with the observed flop
//   clear        in   checker reset, asynchronous, active-low
//   check_en     in   1: compare on this edge, 0: only advance the model
//   dut_d        in   D input as driven into the flop
//   dut_clear    in   flop async clear (active-low) as driven
//   dut_preset   in   flop async preset (active-low) as driven
//   dut_q        in   flop Q output
//   dut_qbar     in   flop Qbar output
//   exp_q        out  predicted Q for the current edge (combinational)
//   mismatch     out  one-cycle pulse, dut_q differed from exp_q
//   compl_err    out  one-cycle pulse, Q/Qbar pair was not legal
//   illegal_seen out  sticky, clear and preset were low together
//   error        out  sticky, any mismatch or complement error since reset
//   err_count    out  saturating count of edges that raised an error
//   chk_count    out  saturating count of edges that were compared
// ---------------------------------------------------------------------------
module dff_response_checker #(
  parameter int ERR_W       = 8,
  parameter int CNT_W       = 16,
  parameter bit HALT_ON_ERR = 1'b0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             check_en,
  input  logic             dut_d,
  input  logic             dut_clear,
  input  logic             dut_preset,
  input  logic             dut_q,
  input  logic             dut_qbar,
  output logic             exp_q,
  output logic             mismatch,
  output logic             compl_err,
  output logic             illegal_seen,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] chk_count
);

  typedef enum logic [1:0] {
    ARMING   = 2'd0,
    CHECKING = 2'd1,
    HALTED   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_model_q;
  logic               r_mismatch;
  logic               r_compl_err;
  logic               r_illegal_seen;
  logic               r_error;
  logic [ERR_W-1:0]   r_err_count;
  logic [CNT_W-1:0]   r_chk_count;

  logic               w_ctl_active;
  logic               w_both_low;
  logic               w_exp_q;
  logic               w_model_next;
  logic               w_q_bad;
  logic               w_compl_bad;
  logic               w_compare;
  logic               w_err_edge;

  // Either async control low overrides the stored value; preset wins when
  // both are low, so in that case the forced value is simply ~dut_preset.
  assign w_ctl_active = ~dut_clear | ~dut_preset;
  assign w_both_low   = ~dut_clear & ~dut_preset;
  assign w_exp_q      = w_ctl_active ? ~dut_preset : r_model_q;
  assign w_model_next = w_ctl_active ? ~dut_preset : dut_d;

  // With both controls low a real flop drives Q and Qbar high together, so
  // that is the only legal pair then; otherwise the outputs must differ.
  assign w_q_bad      = (dut_q != w_exp_q);
  assign w_compl_bad  = w_both_low ? ~(dut_q & dut_qbar) : (dut_q == dut_qbar);

  assign w_compare    = (r_state == CHECKING) && check_en;
  assign w_err_edge   = w_compare && (w_q_bad || w_compl_bad);

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= ARMING;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: arm for one edge, then check until an error halts us
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARMING:   w_next_state = CHECKING;
      CHECKING: if (w_err_edge && HALT_ON_ERR) w_next_state = HALTED;
      HALTED:   w_next_state = HALTED;
      default:  w_next_state = ARMING;
    endcase
  end

  // Reference model runs in every state; results and counters only move
  // while not halted, and only compared edges can raise pulses or counts.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_model_q      <= 1'b0;
      r_mismatch     <= 1'b0;
      r_compl_err    <= 1'b0;
      r_illegal_seen <= 1'b0;
      r_error        <= 1'b0;
      r_err_count    <= '0;
      r_chk_count    <= '0;
    end else begin
      r_model_q   <= w_model_next;
      r_mismatch  <= w_compare && w_q_bad;
      r_compl_err <= w_compare && w_compl_bad;
      if (r_state != HALTED && w_both_low) begin
        r_illegal_seen <= 1'b1;
      end
      if (w_compare && r_chk_count != '1) begin
        r_chk_count <= r_chk_count + CNT_W'(1);
      end
      if (w_err_edge) begin
        r_error <= 1'b1;
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + ERR_W'(1);
        end
      end
    end
  end

  assign exp_q        = w_exp_q;
  assign mismatch     = r_mismatch;
  assign compl_err    = r_compl_err;
  assign illegal_seen = r_illegal_seen;
  assign error        = r_error;
  assign err_count    = r_err_count;
  assign chk_count    = r_chk_count;

endmodule

// File: tb/tb_dff_response_checker.sv
// ---------------------------------------------------------------------------
// tb_dff_response_checker
//   Drives three checker instances (default, halt-on-error, 2-bit error
//   counter) from one shared stimulus stream and compares every output
//   against a per-instance behavioural model after each edge.
// ---------------------------------------------------------------------------
module tb_dff_response_checker;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        checkEn = 1'b0;
  logic        dutD = 1'b0;
  logic        dutClear = 1'b1;
  logic        dutPreset = 1'b1;
  logic        dutQ = 1'b0;
  logic        dutQbar = 1'b1;

  logic [2:0]  oExp;
  logic [2:0]  oMis;
  logic [2:0]  oCompl;
  logic [2:0]  oIll;
  logic [2:0]  oErr;
  logic [7:0]  ecDef;
  logic [7:0]  ecHalt;
  logic [1:0]  ecSat;
  logic [15:0] ccDef;
  logic [15:0] ccHalt;
  logic [15:0] ccSat;

  int compared = 0;
  int mismatched = 0;

  // Behavioural model, one slot per instance: 0 arming, 1 checking, 2 halted
  int mPhase [3];
  bit mQ     [3];
  bit mMis   [3];
  bit mCompl [3];
  bit mIll   [3];
  bit mErr   [3];
  int mErrC  [3];
  int mChkC  [3];
  int errMax [3] = '{255, 255, 3};
  bit haltOn [3] = '{1'b0, 1'b1, 1'b0};

  dff_response_checker #(.ERR_W(8), .CNT_W(16), .HALT_ON_ERR(1'b0)) u_def (
    .clock(clock), .clear(clear), .check_en(checkEn), .dut_d(dutD),
    .dut_clear(dutClear), .dut_preset(dutPreset), .dut_q(dutQ), .dut_qbar(dutQbar),
    .exp_q(oExp[0]), .mismatch(oMis[0]), .compl_err(oCompl[0]),
    .illegal_seen(oIll[0]), .error(oErr[0]), .err_count(ecDef), .chk_count(ccDef));

  dff_response_checker #(.ERR_W(8), .CNT_W(16), .HALT_ON_ERR(1'b1)) u_halt (
    .clock(clock), .clear(clear), .check_en(checkEn), .dut_d(dutD),
    .dut_clear(dutClear), .dut_preset(dutPreset), .dut_q(dutQ), .dut_qbar(dutQbar),
    .exp_q(oExp[1]), .mismatch(oMis[1]), .compl_err(oCompl[1]),
    .illegal_seen(oIll[1]), .error(oErr[1]), .err_count(ecHalt), .chk_count(ccHalt));

  dff_response_checker #(.ERR_W(2), .CNT_W(16), .HALT_ON_ERR(1'b0)) u_sat (
    .clock(clock), .clear(clear), .check_en(checkEn), .dut_d(dutD),
    .dut_clear(dutClear), .dut_preset(dutPreset), .dut_q(dutQ), .dut_qbar(dutQbar),
    .exp_q(oExp[2]), .mismatch(oMis[2]), .compl_err(oCompl[2]),
    .illegal_seen(oIll[2]), .error(oErr[2]), .err_count(ecSat), .chk_count(ccSat));

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clock = ~clock;

  // Predicted Q: a low control forces the flop (preset wins), else stored value
  function automatic bit predictQ(bit stored);
    if (!dutClear || !dutPreset) return !dutPreset;
    return stored;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic resetModels();
    for (int i = 0; i < 3; i++) begin
      mPhase[i] = 0; mQ[i] = 0; mMis[i] = 0; mCompl[i] = 0;
      mIll[i] = 0;   mErr[i] = 0; mErrC[i] = 0; mChkC[i] = 0;
    end
  endtask

  // Advance every model by one rising edge using the current (pre-edge) inputs
  task automatic modelEdge();
    bit illegal;
    bit pairOk;
    bit expQ;
    illegal = !dutClear && !dutPreset;
    pairOk  = illegal ? (dutQ && dutQbar) : (dutQbar != dutQ);
    for (int i = 0; i < 3; i++) begin
      expQ = predictQ(mQ[i]);
      mMis[i] = 0;
      mCompl[i] = 0;
      if (mPhase[i] == 0) begin
        mPhase[i] = 1;
        if (illegal) mIll[i] = 1;
      end else if (mPhase[i] == 1) begin
        if (illegal) mIll[i] = 1;
        if (checkEn) begin
          mChkC[i] = (mChkC[i] < 65535) ? mChkC[i] + 1 : 65535;
          mMis[i] = (dutQ != expQ);
          mCompl[i] = !pairOk;
          if (mMis[i] || mCompl[i]) begin
            mErr[i] = 1;
            mErrC[i] = (mErrC[i] < errMax[i]) ? mErrC[i] + 1 : errMax[i];
            if (haltOn[i]) mPhase[i] = 2;
          end
        end
      end
      mQ[i] = (!dutClear || !dutPreset) ? !dutPreset : dutD;
    end
  endtask

  task automatic checkAll(input string step);
    logic [31:0] ec;
    logic [31:0] cc;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin ec = 32'(ecDef);  cc = 32'(ccDef);  end
        1:       begin ec = 32'(ecHalt); cc = 32'(ccHalt); end
        default: begin ec = 32'(ecSat);  cc = 32'(ccSat);  end
      endcase
      checkOutput($sformatf("%s u%0d.mismatch", step, i), 32'(oMis[i]), 32'(mMis[i]));
      checkOutput($sformatf("%s u%0d.compl_err", step, i), 32'(oCompl[i]), 32'(mCompl[i]));
      checkOutput($sformatf("%s u%0d.illegal_seen", step, i), 32'(oIll[i]), 32'(mIll[i]));
      checkOutput($sformatf("%s u%0d.error", step, i), 32'(oErr[i]), 32'(mErr[i]));
      checkOutput($sformatf("%s u%0d.err_count", step, i), ec, 32'(mErrC[i]));
      checkOutput($sformatf("%s u%0d.chk_count", step, i), cc, 32'(mChkC[i]));
      checkOutput($sformatf("%s u%0d.exp_q", step, i), 32'(oExp[i]), 32'(predictQ(mQ[i])));
    end
  endtask

  // Drive one edge's worth of inputs, check exp_q before the edge, then all
  // registered outputs just after it
  task automatic applyStimulus(input string step, input bit d, input bit clr,
                               input bit pre, input bit en, input bit q, input bit qb);
    dutD = d; dutClear = clr; dutPreset = pre; checkEn = en; dutQ = q; dutQbar = qb;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s u%0d.exp_q_pre", step, i), 32'(oExp[i]), 32'(predictQ(mQ[i])));
    end
    modelEdge();
    @(posedge clock);
    #1;
    checkAll(step);
  endtask

  // Same as applyStimulus but with a well-behaved flop on Q/Qbar
  task automatic applyGood(input string step, input bit d, input bit clr,
                           input bit pre, input bit en);
    bit q;
    q = (!clr || !pre) ? !pre : mQ[0];
    applyStimulus(step, d, clr, pre, en, q, (!clr && !pre) ? 1'b1 : !q);
  endtask

  // Flop with Q inverted but a consistent Qbar: mismatch only
  task automatic applyBadQ(input string step, input bit d);
    bit q;
    q = !mQ[0];
    applyStimulus(step, d, 1'b1, 1'b1, 1'b1, q, !q);
  endtask

  task automatic doReset(input string step);
    dutClear = 1'b1; dutPreset = 1'b1;
    clear = 1'b0;
    #1;
    resetModels();
    checkAll(step);
    clear = 1'b1;
  endtask

  initial begin
    bit q;
    bit qb;
    bit clr;
    bit pre;
    resetModels();

    // Test 1: reset, then a correct flop with D = 1, 0, 1
    #2;
    doReset("t1_reset");
    applyGood("t1_e1", 1'b1, 1'b1, 1'b1, 1'b1);
    applyGood("t1_e2", 1'b0, 1'b1, 1'b1, 1'b1);
    applyGood("t1_e3", 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("t1_chk_count_const", 32'(ccDef), 32'd2);
    checkOutput("t1_error_const", 32'(oErr[0]), 32'd0);

    // Test 2: clear held low for two edges, second edge has a wrong Q
    applyStimulus("t2_e1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus("t2_e2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("t2_mismatch_const", 32'(oMis[0]), 32'd1);
    checkOutput("t2_err_count_const", 32'(ecDef), 32'd1);

    // Test 3: preset low, Q and Qbar both high -> complement error only
    applyStimulus("t3", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t3_compl_const", 32'(oCompl[0]), 32'd1);
    checkOutput("t3_mis_const", 32'(oMis[0]), 32'd0);

    // Test 4: both controls low with Q=Qbar=1 is legal, then release
    applyStimulus("t4_both", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t4_illegal_const", 32'(oIll[0]), 32'd1);
    checkOutput("t4_err_count_const", 32'(ecDef), 32'd2);
    dutClear = 1'b1; dutPreset = 1'b1;
    #1;
    checkOutput("t4_release_expq_const", 32'(oExp[0]), 32'd1);
    applyGood("t4_capture", 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t4_after_capture_expq_const", 32'(oExp[0]), 32'd0);

    // check_en low: model advances, nothing compared
    applyStimulus("t4_noen", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

    // Test 5: halt-on-error instance freezes after its first error
    doReset("t5_reset");
    applyGood("t5_arm", 1'b1, 1'b1, 1'b1, 1'b1);
    applyBadQ("t5_bad0", 1'b0);
    for (int k = 0; k < 5; k++) applyBadQ($sformatf("t5_bad%0d", k + 1), k[0]);
    checkOutput("t5_halt_err_count_const", 32'(ecHalt), 32'd1);
    checkOutput("t5_halt_chk_count_const", 32'(ccHalt), 32'd1);
    doReset("t5_clear");

    // Test 6: 2-bit error counter saturates at 3
    applyGood("t6_arm", 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) applyBadQ($sformatf("t6_bad%0d", k), k[1]);
    checkOutput("t6_sat_err_count_const", 32'(ecSat), 32'd3);

    // Randomised run with occasional bad Q/Qbar and a mid-run reset
    doReset("rnd_reset");
    for (int n = 0; n < 400; n++) begin
      if (n == 200) doReset("rnd_midreset");
      clr = ($urandom_range(0, 7) != 0);
      pre = ($urandom_range(0, 7) != 0);
      q   = (!clr || !pre) ? !pre : mQ[0];
      if ($urandom_range(0, 9) == 0) q = !q;
      qb  = (!clr && !pre) ? 1'b1 : !q;
      if ($urandom_range(0, 9) == 0) qb = !qb;
      applyStimulus($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), clr, pre,
                    ($urandom_range(0, 5) != 0), q, qb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
